// File: rtl/seq_alu_pkg.sv
// Shared opcodes, FSM state encoding and opcode classification for seq_alu.
// SEQ_ALU_DIV_EN decides whether DIVU/REMU are multi-cycle or illegal.
package seq_alu_pkg;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_XOR   = 4'b0011;
  localparam logic [3:0] OP_SLL   = 4'b0100;
  localparam logic [3:0] OP_SRL   = 4'b0101;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_MUL   = 4'b1000;
  localparam logic [3:0] OP_MULHU = 4'b1001;
  localparam logic [3:0] OP_DIVU  = 4'b1010;
  localparam logic [3:0] OP_REMU  = 4'b1011;
  localparam logic [3:0] OP_NOR   = 4'b1100;
  localparam logic [3:0] OP_SRA   = 4'b1101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Divide by zero is still resolved in one cycle; the caller screens it out.
  function automatic logic is_multi_cycle(input logic [3:0] op);
`ifdef SEQ_ALU_DIV_EN
    return (op == OP_MUL) || (op == OP_MULHU) || (op == OP_DIVU) || (op == OP_REMU);
`else
    return (op == OP_MUL) || (op == OP_MULHU);
`endif
  endfunction

endpackage

// File: rtl/seq_alu_muldiv.sv
// Iterative unsigned shift-add multiplier and (with SEQ_ALU_DIV_EN) restoring divider.
// Both share one WIDTH-bit adder, the hi/lo/operand registers and the iteration counter.
module seq_alu_muldiv import seq_alu_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] res
);

  localparam int CW = $clog2(WIDTH);

  logic             active;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] opnd;
  logic             take_hi;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic             add_cin;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic [WIDTH-1:0] hi_next;
  logic [WIDTH-1:0] lo_next;

`ifdef SEQ_ALU_DIV_EN
  logic             div_mode;
  logic             is_div;
  logic [WIDTH-1:0] rem_sh;
  logic             sub_ok;

  assign is_div = (op == OP_DIVU) || (op == OP_REMU);
  assign rem_sh = {hi[WIDTH-2:0], lo[WIDTH-1]};
`endif

  assign {cout, sum} = {1'b0, add_a} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};

  always_comb begin
    add_a   = hi;
    add_b   = lo[0] ? opnd : '0;
    add_cin = 1'b0;
`ifdef SEQ_ALU_DIV_EN
    if (div_mode) begin
      add_a   = rem_sh;
      add_b   = ~opnd;
      add_cin = 1'b1;
    end
`endif
  end

  // A set top bit in hi means the shifted remainder exceeds any divisor.
  always_comb begin
    hi_next = {cout, sum[WIDTH-1:1]};
    lo_next = {sum[0], lo[WIDTH-1:1]};
`ifdef SEQ_ALU_DIV_EN
    sub_ok = hi[WIDTH-1] | cout;
    if (div_mode) begin
      hi_next = sub_ok ? sum : rem_sh;
      lo_next = {lo[WIDTH-2:0], sub_ok};
    end
`endif
  end

  assign done = active && (cnt == CW'(WIDTH - 1));
  assign res  = take_hi ? hi_next : lo_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      active  <= 1'b0;
      cnt     <= '0;
      hi      <= '0;
      lo      <= '0;
      opnd    <= '0;
      take_hi <= 1'b0;
`ifdef SEQ_ALU_DIV_EN
      div_mode <= 1'b0;
`endif
    end else if (start) begin
      active  <= 1'b1;
      cnt     <= '0;
      hi      <= '0;
      take_hi <= (op == OP_MULHU) || (op == OP_REMU);
`ifdef SEQ_ALU_DIV_EN
      div_mode <= is_div;
      lo       <= is_div ? a : b;
      opnd     <= is_div ? b : a;
`else
      lo       <= b;
      opnd     <= a;
`endif
    end else if (active) begin
      hi  <= hi_next;
      lo  <= lo_next;
      cnt <= cnt + CW'(1);
      if (done) active <= 1'b0;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// Handshaked sequential ALU: registered result and flags, iterative MUL/MULHU,
// and DIVU/REMU only when SEQ_ALU_DIV_EN is defined (illegal opcodes otherwise).
module seq_alu import seq_alu_pkg::*; #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] data1,
  input  logic [WIDTH-1:0] data2,
  input  logic [3:0]       ALUop,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             illegal,
  output logic             div_zero
);

  localparam int SHW = $clog2(WIDTH);

  state_t           state;
  logic             accept;
  logic             is_div;
  logic             div_by_zero;
  logic             start_mc;
  logic             md_done;
  logic [WIDTH-1:0] md_res;
  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;
  logic             alu_ill;
  logic             alu_dz;

  assign accept = in_valid && in_ready;
  assign shamt  = data2[SHW-1:0];

`ifdef SEQ_ALU_DIV_EN
  assign is_div = (ALUop == OP_DIVU) || (ALUop == OP_REMU);
`else
  assign is_div = 1'b0;
`endif
  assign div_by_zero = is_div && (data2 == '0);
  assign start_mc    = accept && is_multi_cycle(ALUop) && !div_by_zero;

  seq_alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk   (clk),
    .rst   (rst),
    .start (start_mc),
    .op    (ALUop),
    .a     (data1),
    .b     (data2),
    .done  (md_done),
    .res   (md_res)
  );

  // Single-cycle datapath; DIVU/REMU arms only matter for a zero divisor.
  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    alu_ill = 1'b0;
    alu_dz  = 1'b0;
    case (ALUop)
      OP_AND: alu_res = data1 & data2;
      OP_OR:  alu_res = data1 | data2;
      OP_XOR: alu_res = data1 ^ data2;
      OP_NOR: alu_res = ~(data1 | data2);
      OP_ADD: begin
        alu_res = data1 + data2;
        alu_ovf = (data1[WIDTH-1] == data2[WIDTH-1]) && (alu_res[WIDTH-1] != data1[WIDTH-1]);
      end
      OP_SUB: begin
        alu_res = data1 - data2;
        alu_ovf = (data1[WIDTH-1] != data2[WIDTH-1]) && (alu_res[WIDTH-1] != data1[WIDTH-1]);
      end
      OP_SLL: alu_res = data1 << shamt;
      OP_SRL: alu_res = data1 >> shamt;
      OP_SRA: alu_res = $signed(data1) >>> shamt;
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, $signed(data1) < $signed(data2)};
      OP_MUL, OP_MULHU: alu_res = '0;
`ifdef SEQ_ALU_DIV_EN
      OP_DIVU: begin
        alu_res = '1;
        alu_dz  = 1'b1;
      end
      OP_REMU: begin
        alu_res = data1;
        alu_dz  = 1'b1;
      end
`endif
      default: alu_ill = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
      illegal   <= 1'b0;
      div_zero  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            in_ready <= 1'b0;
            if (start_mc) begin
              state <= ST_BUSY;
            end else begin
              state     <= ST_DONE;
              out_valid <= 1'b1;
              result    <= alu_res;
              zero      <= (alu_res == '0);
              overflow  <= alu_ovf;
              illegal   <= alu_ill;
              div_zero  <= alu_dz;
            end
          end
        end
        ST_BUSY: begin
          if (md_done) begin
            state     <= ST_DONE;
            out_valid <= 1'b1;
            result    <= md_res;
            zero      <= (md_res == '0);
            overflow  <= 1'b0;
            illegal   <= 1'b0;
            div_zero  <= 1'b0;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state     <= ST_IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu (WIDTH=32): directed scenarios plus randomized
// operations checked against an arithmetic reference model; honours SEQ_ALU_DIV_EN.
module tb_seq_alu;

  localparam int W = 32;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] data1;
  logic [W-1:0] data2;
  logic [3:0]   alu_op;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         zero;
  logic         overflow;
  logic         illegal;
  logic         div_zero;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [W-1:0] r;
    logic         z;
    logic         ov;
    logic         il;
    logic         dz;
    int           lat;
  } exp_t;

  seq_alu #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data1     (data1),
    .data2     (data2),
    .ALUop     (alu_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .overflow  (overflow),
    .illegal   (illegal),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "[TB] watchdog");
  end

  // Reference model: true integer arithmetic, overflow as an out-of-range signed sum.
  function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t           e;
    longint         sa;
    longint         sb;
    longint         t;
    logic [2*W-1:0] p;
    int             sh;
    e.r = '0; e.z = 1'b0; e.ov = 1'b0; e.il = 1'b0; e.dz = 1'b0; e.lat = 1;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    sh = int'(b % W);
    p  = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    case (op)
      4'd0:  e.r = a & b;
      4'd1:  e.r = a | b;
      4'd2:  begin t = sa + sb; e.r = a + b; e.ov = (t > SMAX) || (t < SMIN); end
      4'd3:  e.r = a ^ b;
      4'd4:  e.r = a << sh;
      4'd5:  e.r = a >> sh;
      4'd6:  begin t = sa - sb; e.r = a - b; e.ov = (t > SMAX) || (t < SMIN); end
      4'd7:  e.r = (sa < sb) ? 32'd1 : 32'd0;
      4'd8:  begin e.r = p[W-1:0];   e.lat = W + 1; end
      4'd9:  begin e.r = p[2*W-1:W]; e.lat = W + 1; end
`ifdef SEQ_ALU_DIV_EN
      4'd10: if (b == 0) begin e.r = '1; e.dz = 1'b1; end
             else begin e.r = a / b; e.lat = W + 1; end
      4'd11: if (b == 0) begin e.r = a; e.dz = 1'b1; end
             else begin e.r = a % b; e.lat = W + 1; end
`endif
      4'd12: e.r = ~(a | b);
      4'd13: begin t = sa >>> sh; e.r = t[W-1:0]; end
      default: e.il = 1'b1;
    endcase
    e.z = (e.r == 0);
    return e;
  endfunction

  // Issues one operation, then records latency, cycles with in_ready low, and outputs.
  task automatic do_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       output exp_t o, output int rdy_low);
    int n;
    in_valid = 1'b1; alu_op = op; data1 = a; data2 = b;
    n = 0;
    while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    in_valid = 1'b0; alu_op = 4'($urandom); data1 = $urandom; data2 = $urandom;
    o.lat = 1; rdy_low = 0;
    while (!out_valid && o.lat < 100) begin
      if (!in_ready) rdy_low++;
      @(posedge clk); #1; o.lat++;
    end
    if (!in_ready) rdy_low++;
    if (!out_valid) o.lat = -1;
    o.r = result; o.z = zero; o.ov = overflow; o.il = illegal; o.dz = div_zero;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b1; alu_op = 4'd2; data1 = 32'd1; data2 = 32'd1; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_in_valid_ignored out_valid=%b want=0", out_valid); end
    in_valid = 1'b0; rst = 1'b0;
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_in_ready got=%b want=1", in_ready); end
    total++; if (result !== '0) begin bad++; $display("[TB] FAIL reset_result got=%h want=0", result); end
    total++; if ({out_valid, zero, overflow, illegal, div_zero} !== 5'b0) begin
      bad++; $display("[TB] FAIL reset_flags got=%b want=00000", {out_valid, zero, overflow, illegal, div_zero});
    end
  endtask

  task automatic test_add_sub();
    exp_t o; int rl;
    do_op(4'd2, 32'd1, 32'd2, o, rl);
    total++; if (o.lat !== 1) begin bad++; $display("[TB] FAIL add_latency got=%0d want=1", o.lat); end
    total++; if ({o.r, o.z, o.ov} !== {32'd3, 1'b0, 1'b0}) begin bad++; $display("[TB] FAIL add_1_2 got=%h z=%b ov=%b want=3 z=0 ov=0", o.r, o.z, o.ov); end
    drain();
    do_op(4'd6, 32'd4, 32'd3, o, rl);
    total++; if (o.lat !== 1) begin bad++; $display("[TB] FAIL sub_latency got=%0d want=1", o.lat); end
    total++; if ({o.r, o.z, o.ov} !== {32'd1, 1'b0, 1'b0}) begin bad++; $display("[TB] FAIL sub_4_3 got=%h z=%b ov=%b want=1 z=0 ov=0", o.r, o.z, o.ov); end
    drain();
  endtask

  task automatic test_overflow();
    exp_t o; int rl;
    do_op(4'd2, 32'h7FFFFFFF, 32'd1, o, rl);
    total++; if ({o.r, o.ov} !== {32'h80000000, 1'b1}) begin bad++; $display("[TB] FAIL add_overflow got=%h ov=%b want=80000000 ov=1", o.r, o.ov); end
    drain();
    do_op(4'd6, 32'd5, 32'd5, o, rl);
    total++; if ({o.r, o.z, o.ov} !== {32'd0, 1'b1, 1'b0}) begin bad++; $display("[TB] FAIL sub_zero got=%h z=%b ov=%b want=0 z=1 ov=0", o.r, o.z, o.ov); end
    drain();
  endtask

  task automatic test_mul();
    exp_t o; int rl;
    do_op(4'd8, 32'd7, 32'd6, o, rl);
    total++; if (o.lat !== 33) begin bad++; $display("[TB] FAIL mul_latency got=%0d want=33", o.lat); end
    total++; if (rl !== 33) begin bad++; $display("[TB] FAIL mul_ready_low got=%0d want=33", rl); end
    total++; if (o.r !== 32'd42) begin bad++; $display("[TB] FAIL mul_7_6 got=%h want=2a", o.r); end
    drain();
    do_op(4'd9, 32'hFFFFFFFF, 32'd2, o, rl);
    total++; if ({o.r, o.lat} !== {32'd1, 32'd33}) begin bad++; $display("[TB] FAIL mulhu got=%h lat=%0d want=1 lat=33", o.r, o.lat); end
    drain();
  endtask

  task automatic test_div();
    exp_t o; int rl;
`ifdef SEQ_ALU_DIV_EN
    do_op(4'd10, 32'd100, 32'd7, o, rl);
    total++; if ({o.r, o.lat} !== {32'd14, 32'd33}) begin bad++; $display("[TB] FAIL divu got=%0d lat=%0d want=14 lat=33", o.r, o.lat); end
    drain();
    do_op(4'd11, 32'd100, 32'd7, o, rl);
    total++; if ({o.r, o.lat} !== {32'd2, 32'd33}) begin bad++; $display("[TB] FAIL remu got=%0d lat=%0d want=2 lat=33", o.r, o.lat); end
    drain();
    do_op(4'd10, 32'd9, 32'd0, o, rl);
    total++; if ({o.r, o.dz, o.il, o.lat} !== {32'hFFFFFFFF, 1'b1, 1'b0, 32'd1}) begin
      bad++; $display("[TB] FAIL divu_by_zero got=%h dz=%b il=%b lat=%0d want=ffffffff dz=1 il=0 lat=1", o.r, o.dz, o.il, o.lat);
    end
    drain();
    do_op(4'd11, 32'd9, 32'd0, o, rl);
    total++; if ({o.r, o.dz, o.lat} !== {32'd9, 1'b1, 32'd1}) begin bad++; $display("[TB] FAIL remu_by_zero got=%h dz=%b lat=%0d want=9 dz=1 lat=1", o.r, o.dz, o.lat); end
    drain();
`else
    do_op(4'd10, 32'd9, 32'd3, o, rl);
    total++; if ({o.r, o.il, o.dz, o.lat} !== {32'd0, 1'b1, 1'b0, 32'd1}) begin
      bad++; $display("[TB] FAIL divu_disabled got=%h il=%b dz=%b lat=%0d want=0 il=1 dz=0 lat=1", o.r, o.il, o.dz, o.lat);
    end
    drain();
`endif
    do_op(4'd14, 32'd9, 32'd3, o, rl);
    total++; if ({o.r, o.il, o.lat} !== {32'd0, 1'b1, 32'd1}) begin bad++; $display("[TB] FAIL op14_illegal got=%h il=%b lat=%0d want=0 il=1 lat=1", o.r, o.il, o.lat); end
    drain();
  endtask

  task automatic test_backpressure();
    exp_t o; int rl;
    do_op(4'd3, 32'hF0, 32'hFF, o, rl);
    total++; if (o.r !== 32'h0F) begin bad++; $display("[TB] FAIL xor_result got=%h want=0f", o.r); end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      total++; if ({result, out_valid, in_ready} !== {32'h0F, 1'b1, 1'b0}) begin
        bad++; $display("[TB] FAIL hold_cycle%0d got=%h ov=%b ir=%b want=0f ov=1 ir=0", i, result, out_valid, in_ready);
      end
    end
    drain();
    total++; if ({out_valid, in_ready} !== 2'b01) begin bad++; $display("[TB] FAIL release_idle got ov=%b ir=%b want ov=0 ir=1", out_valid, in_ready); end
  endtask

  task automatic test_reset_mid_mul();
    exp_t o; int rl; int seen;
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL mm_ready_before got=%b want=1", in_ready); end
    in_valid = 1'b1; alu_op = 4'd8; data1 = 32'd7; data2 = 32'd6;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    total++; if ({out_valid, result} !== {1'b0, 32'd0}) begin bad++; $display("[TB] FAIL mm_in_reset ov=%b r=%h want ov=0 r=0", out_valid, result); end
    @(posedge clk); #1;
    rst = 1'b0;
    total++; if ({in_ready, out_valid, result} !== {1'b1, 1'b0, 32'd0}) begin
      bad++; $display("[TB] FAIL mm_after_reset ir=%b ov=%b r=%h want ir=1 ov=0 r=0", in_ready, out_valid, result);
    end
    seen = 0;
    for (int i = 0; i < 40; i++) begin @(posedge clk); #1; if (out_valid) seen++; end
    total++; if (seen !== 0) begin bad++; $display("[TB] FAIL mm_discarded stray_valid_cycles=%0d want=0", seen); end
    do_op(4'd4, 32'd1, 32'd35, o, rl);
    total++; if ({o.r, o.lat} !== {32'd8, 32'd1}) begin bad++; $display("[TB] FAIL sll_after_reset got=%h lat=%0d want=8 lat=1", o.r, o.lat); end
    drain();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] exp_q[$];
    logic [W-1:0] a, b, want;
    int issued, got, last_acc;
    out_ready = 1'b1; issued = 0; got = 0; last_acc = -1;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      if (out_valid && exp_q.size() > 0) begin
        want = exp_q.pop_front(); got++;
        total++; if (result !== want) begin bad++; $display("[TB] FAIL b2b_result%0d got=%h want=%h", got, result, want); end
      end
      if (in_ready && issued < 4) begin
        a = $urandom; b = $urandom;
        in_valid = 1'b1; alu_op = 4'd2; data1 = a; data2 = b;
        exp_q.push_back(a + b);
        if (last_acc >= 0) begin
          total++; if (cyc - last_acc !== 2) begin bad++; $display("[TB] FAIL b2b_interval got=%0d want=2", cyc - last_acc); end
        end
        last_acc = cyc; issued++;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    total++; if (got !== 4) begin bad++; $display("[TB] FAIL b2b_count got=%0d want=4", got); end
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    exp_t o; exp_t e; int rl; int hold;
    logic [3:0] op; logic [W-1:0] a, b;
    for (int n = 0; n < 60; n++) begin
      op = 4'($urandom_range(0, 15));
      a = $urandom; b = $urandom;
      case ($urandom_range(0, 7))
        0: b = '0;
        1: a = 32'h7FFFFFFF;
        2: a = 32'h80000000;
        3: b = 32'($urandom_range(1, 300));
        4: begin a = 32'($urandom_range(0, 1000)); b = a; end
        default: ;
      endcase
      e = model(op, a, b);
      do_op(op, a, b, o, rl);
      total++; if (o.r !== e.r) begin bad++; $display("[TB] FAIL rand%0d_result op=%0d a=%h b=%h got=%h want=%h", n, op, a, b, o.r, e.r); end
      total++; if ({o.z, o.ov, o.il, o.dz} !== {e.z, e.ov, e.il, e.dz}) begin
        bad++; $display("[TB] FAIL rand%0d_flags op=%0d got=%b want=%b", n, op, {o.z, o.ov, o.il, o.dz}, {e.z, e.ov, e.il, e.dz});
      end
      total++; if (o.lat !== e.lat) begin bad++; $display("[TB] FAIL rand%0d_latency op=%0d got=%0d want=%0d", n, op, o.lat, e.lat); end
      hold = $urandom_range(0, 3);
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); #1;
        total++; if ({out_valid, result} !== {1'b1, e.r}) begin bad++; $display("[TB] FAIL rand%0d_hold ov=%b got=%h want=%h", n, out_valid, result, e.r); end
      end
      drain();
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; alu_op = '0; data1 = '0; data2 = '0;
    test_reset();
    test_add_sub();
    test_overflow();
    test_mul();
    test_div();
    test_backpressure();
    test_reset_mid_mul();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
Name: seq_alu

Overview:
- Parametrised, handshaked successor to the processor's combinational ALU.
- Adds a registered result, status flags, and an iterative multiply unit, with an optional iterative divide unit.
- Sits between decode/operand-fetch and writeback. It is intended for the multi-cycle datapath, where long operations stall issue through the valid/ready handshake.

Parameters:
- WIDTH, 32, operand and result width in bits. Must be 8..64 and a power of two.
- SHW, $clog2(WIDTH), shift-amount width. Derived localparam, not overridable.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands and opcode are valid.
- in_ready  output  1  block can accept an operation.
- data1  input  WIDTH  operand A.
- data2  input  WIDTH  operand B.
- ALUop  input  4  operation select.
- out_valid  output  1  result and flags are valid.
- out_ready  input  1  consumer accepts the result.
- result  output  WIDTH  registered result.
- zero  output  1  result == 0.
- overflow  output  1  signed overflow on ADD/SUB; 0 for all other ops.
- illegal  output  1  opcode unsupported; result forced to 0.
- div_zero  output  1  DIVU/REMU issued with data2 == 0.

Behaviour:
- Opcodes:
  - 0000 AND, 0001 OR, 0010 ADD, 0011 XOR
  - 0100 SLL, 0101 SRL, 0110 SUB, 0111 SLT (signed; result 1 or 0)
  - 1000 MUL (low WIDTH bits), 1001 MULHU (high WIDTH bits, unsigned)
  - 1010 DIVU, 1011 REMU
  - 1100 NOR, 1101 SRA
  - 1110 and 1111 are illegal.
- Shift ops use data2[SHW-1:0]; higher bits of data2 are ignored.
- ADD/SUB wrap modulo 2^WIDTH.
- overflow = (A and B share a sign and the result's sign differs), with B inverted for SUB.
- FSM states: IDLE, BUSY, DONE.
  - in_ready = 1 only in IDLE.
  - Accept when in_valid && in_ready.
- Single-cycle ops (including illegal ops and divide-by-zero):
  - IDLE -> DONE.
  - Result and flags are registered on the accept edge, so out_valid = 1 on the next cycle (latency 1).
- MUL/MULHU:
  - IDLE -> BUSY, then exactly WIDTH shift-add iterations.
  - BUSY -> DONE after the WIDTH-th iteration; out_valid is asserted WIDTH+1 cycles after accept.
  - The 2*WIDTH-bit product is formed unsigned.
- DIVU/REMU: restoring division, same latency (WIDTH+1).
- Divide by zero:
  - No iterations; latency 1.
  - DIVU result = all ones; REMU result = data1; div_zero = 1.
- DONE:
  - result and all flags are held stable while out_valid && !out_ready.
  - On out_ready: DONE -> IDLE, out_valid drops the next cycle.
  - There is no accept in the same cycle as drain, so the minimum issue interval is 2 cycles.
- Operands are captured at accept; input changes during BUSY or DONE have no effect.
- zero is computed from the final registered result.
- Reset (asynchronous, at any time, including mid-BUSY):
  - state = IDLE, iteration counter = 0, result = 0, all flags = 0, out_valid = 0.
  - in_ready = 1 on the first cycle after rst deasserts.
  - Any in-flight operation is discarded.
- in_valid during reset is ignored.

Optional Feature:
- Macro: SEQ_ALU_DIV_EN.
- Defined: the DIVU/REMU datapath is present, behaving as above.
- Undefined:
  - No divider logic is built.
  - 1010/1011 are treated as illegal: latency 1, result 0, illegal = 1, div_zero = 0.

Decomposition:
- Package seq_alu_pkg:
  - opcode localparams (OP_AND ... OP_SRA)
  - FSM state encoding (ST_IDLE, ST_BUSY, ST_DONE)
  - a function to classify an opcode as multi-cycle.
- Sub-module seq_alu_muldiv:
  - iterative shift-add multiplier and restoring divider, sharing one WIDTH-bit adder and the iteration counter
  - start/done interface to the parent FSM
  - divider section guarded by SEQ_ALU_DIV_EN.

Test Plan:
1. WIDTH=32. ADD 1+2, then SUB 4-3:
   - out_valid one cycle after each accept.
   - result 3 then 1; zero = 0; overflow = 0.
2. ADD 0x7FFFFFFF+1:
   - result 0x80000000, overflow = 1.
   - Then SUB 5-5: result 0, zero = 1.
3. MUL 7*6:
   - in_ready low for 33 cycles; out_valid at cycle 33 after accept; result 42.
   - MULHU 0xFFFFFFFF*2 -> result 1.
4. With SEQ_ALU_DIV_EN:
   - DIVU 100/7 -> 14 and REMU 100/7 -> 2, each at latency 33.
   - DIVU 9/0 -> 0xFFFFFFFF, div_zero = 1, latency 1.
   - Without the macro: DIVU 9/3 -> result 0, illegal = 1.
5. Backpressure: hold out_ready = 0 for 10 cycles after XOR 0xF0^0xFF:
   - result stays 0x0F, out_valid stays high, in_ready stays low.
   - Release out_ready: IDLE on the next cycle.
6. Assert rst at cycle 10 of a MUL:
   - out_valid = 0, result = 0, in_ready = 1 after release.
   - A following SLL 1<<35 returns 8 (shift amount 35 mod 32 = 3).
